// File: rtl/memory_game_if.sv
// Shuffler and card-pick handshakes between the memory game controller (slave)
// and the shuffler / input-selector logic (master).
interface memory_game_if;
    logic             shuf_start;
    logic             shuf_done;
    logic [15:0][4:0] shuf_cards;
    logic             pick_valid;
    logic [3:0]       pick_idx;
    logic             pick_ready;
    logic             pick_err;

    modport master (
        input  shuf_start, pick_ready, pick_err,
        output shuf_done, shuf_cards, pick_valid, pick_idx
    );

    modport slave (
        output shuf_start, pick_ready, pick_err,
        input  shuf_done, shuf_cards, pick_valid, pick_idx
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the 4x4 memory-match game: shuffle, pick, compare, score.
// Optional per-turn timeout enabled by defining MEMORY_GAME_TURN_TIMEOUT_EN.
module memory_game_ctrl #(
    parameter int SHOW_CYCLES = 50_000_000
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 750_000_000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    memory_game_if.slave     bus,
    output logic [15:0][4:0] cards_out,
    output logic             cur_player,
    output logic [3:0]       score0,
    output logic [3:0]       score1,
    output logic             mismatch,
    output logic             game_over
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
    , output logic           timeout
`endif
);

    typedef enum logic [2:0] {IDLE, SHUF, FIRST, SECOND, CMP, SHOW, DONE} state_t;

    localparam logic [1:0] ST_HIDDEN  = 2'b00;
    localparam logic [1:0] ST_UP      = 2'b01;
    localparam logic [1:0] ST_MATCHED = 2'b10;
    localparam int         SHOW_W     = $clog2(SHOW_CYCLES + 1);

    state_t            state;
    logic              armed;
    logic [3:0]        idx_a;
    logic [3:0]        idx_b;
    logic [3:0]        pairs;
    logic [SHOW_W-1:0] show_cnt;
    logic              pick_ok;
    logic              unused_low_bits;

`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
    localparam int TURN_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TURN_W-1:0] turn_cnt;
`endif

    assign pick_ok = bus.pick_valid && (cards_out[bus.pick_idx][1:0] == ST_HIDDEN);

    // The shuffler's two low bits carry no symbol information.
    always_comb begin
        unused_low_bits = 1'b0;
        for (int k = 0; k < 16; k++) unused_low_bits = unused_low_bits ^ (^bus.shuf_cards[k][1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the card array is cleared on reset because the renderer reads it directly.
            state          <= IDLE;
            armed          <= 1'b0;
            idx_a          <= '0;
            idx_b          <= '0;
            pairs          <= 4'd8;
            show_cnt       <= '0;
            bus.shuf_start <= 1'b0;
            bus.pick_ready <= 1'b0;
            bus.pick_err   <= 1'b0;
            cards_out      <= '0;
            cur_player     <= 1'b0;
            score0         <= '0;
            score1         <= '0;
            mismatch       <= 1'b0;
            game_over      <= 1'b0;
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
            turn_cnt       <= '0;
            timeout        <= 1'b0;
`endif
        end else begin
            bus.shuf_start <= 1'b0;
            bus.pick_err   <= 1'b0;
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
            timeout        <= 1'b0;
            // Holding the load value outside a turn makes every FIRST entry start fresh.
            if (!(state inside {FIRST, SECOND})) turn_cnt <= TURN_W'(TIMEOUT_CYCLES - 1);
`endif
            if (new_game) begin
                state          <= SHUF;
                armed          <= 1'b0;
                pairs          <= 4'd8;
                bus.shuf_start <= 1'b1;
                bus.pick_ready <= 1'b0;
                cur_player     <= 1'b0;
                score0         <= '0;
                score1         <= '0;
                mismatch       <= 1'b0;
                game_over      <= 1'b0;
            end else begin
                case (state)
                    SHUF: begin
                        // Arming on a low done level skips the previous game's stale high.
                        if (!armed) begin
                            if (!bus.shuf_done) armed <= 1'b1;
                        end else if (bus.shuf_done) begin
                            for (int k = 0; k < 16; k++) cards_out[k] <= {bus.shuf_cards[k][4:2], ST_HIDDEN};
                            state          <= FIRST;
                            bus.pick_ready <= 1'b1;
                        end
                    end
                    FIRST, SECOND: begin
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
                        if (turn_cnt != '0) turn_cnt <= turn_cnt - 1'b1;
`endif
                        if (pick_ok) begin
                            cards_out[bus.pick_idx][1:0] <= ST_UP;
                            if (state == FIRST) begin
                                idx_a <= bus.pick_idx;
                                state <= SECOND;
                            end else begin
                                idx_b          <= bus.pick_idx;
                                state          <= CMP;
                                bus.pick_ready <= 1'b0;
                            end
                        end else begin
                            if (bus.pick_valid) bus.pick_err <= 1'b1;
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
                            if (turn_cnt == '0) begin
                                if (state == SECOND) cards_out[idx_a][1:0] <= ST_HIDDEN;
                                cur_player <= ~cur_player;
                                state      <= FIRST;
                                turn_cnt   <= TURN_W'(TIMEOUT_CYCLES - 1);
                                timeout    <= 1'b1;
                            end
`else
                            // Without the turn timer a turn waits for a pick indefinitely.
`endif
                        end
                    end
                    CMP: begin
                        if (cards_out[idx_a][4:2] == cards_out[idx_b][4:2]) begin
                            cards_out[idx_a][1:0] <= ST_MATCHED;
                            cards_out[idx_b][1:0] <= ST_MATCHED;
                            if (cur_player) score1 <= score1 + 4'd1;
                            else            score0 <= score0 + 4'd1;
                            pairs <= pairs - 4'd1;
                            if (pairs == 4'd1) begin
                                state     <= DONE;
                                game_over <= 1'b1;
                            end else begin
                                state          <= FIRST;
                                bus.pick_ready <= 1'b1;
                            end
                        end else begin
                            state    <= SHOW;
                            show_cnt <= SHOW_W'(SHOW_CYCLES - 1);
                            mismatch <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (show_cnt == '0) begin
                            cards_out[idx_a][1:0] <= ST_HIDDEN;
                            cards_out[idx_b][1:0] <= ST_HIDDEN;
                            cur_player     <= ~cur_player;
                            mismatch       <= 1'b0;
                            state          <= FIRST;
                            bus.pick_ready <= 1'b1;
                        end else begin
                            show_cnt <= show_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Randomized self-checking bench for memory_game_ctrl against a game-level model.
module tb_memory_game_ctrl;
    localparam int SHOW = 4;
    localparam int TMO  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             new_game;
    logic [15:0][4:0] cards_out;
    logic             cur_player;
    logic [3:0]       score0;
    logic [3:0]       score1;
    logic             mismatch;
    logic             game_over;
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
    logic             timeout;
`endif

    memory_game_if bus();

    memory_game_ctrl #(
        .SHOW_CYCLES(SHOW)
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .new_game(new_game),
        .bus(bus),
        .cards_out(cards_out),
        .cur_player(cur_player),
        .score0(score0),
        .score1(score1),
        .mismatch(mismatch),
        .game_over(game_over)
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sym_m[16];
    int st_m[16];
    int score_m[2];
    int player_m;
    int pairs_m;
    int first_m;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] cards_exp();
        logic [15:0][4:0] c;
        for (int k = 0; k < 16; k++) c[k] = {3'(sym_m[k]), 2'(st_m[k])};
        return c;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_cards"}, cards_out, cards_exp());
        check({tag, "_score0"}, score0, score_m[0]);
        check({tag, "_score1"}, score1, score_m[1]);
        check({tag, "_player"}, cur_player, player_m);
    endtask

    // Eight symbol pairs in random positions; the directed deck pins 3/9 as a pair and 0/1 apart.
    task automatic make_deck(input bit directed);
        int j;
        int t;
        for (int k = 0; k < 16; k++) sym_m[k] = k / 2;
        for (int k = 15; k > 0; k--) begin
            j = $urandom_range(k, 0);
            t = sym_m[k]; sym_m[k] = sym_m[j]; sym_m[j] = t;
        end
        if (directed) begin
            for (int k = 0; k < 16; k++)
                if (k != 3 && sym_m[k] == sym_m[3]) j = k;
            t = sym_m[9]; sym_m[9] = sym_m[j]; sym_m[j] = t;
            if (sym_m[0] == sym_m[1]) begin
                t = sym_m[1]; sym_m[1] = sym_m[4]; sym_m[4] = t;
            end
        end
        for (int k = 0; k < 16; k++) st_m[k] = 0;
    endtask

    task automatic start_game(input bit directed);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        score_m[0] = 0; score_m[1] = 0; player_m = 0; pairs_m = 8; first_m = -1;
        check("shuf_start_pulse", bus.shuf_start, 1'b1);
        check("ng_score0", score0, 0);
        check("ng_score1", score1, 0);
        check("ng_player", cur_player, 0);
        check("ng_mismatch", mismatch, 1'b0);
        check("ng_game_over", game_over, 1'b0);
        bus.pick_valid = 1'b1;
        bus.pick_idx   = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_done_ready", bus.pick_ready, 1'b0);
            check("shuf_pick_err", bus.pick_err, 1'b0);
            check("shuf_start_once", bus.shuf_start, 1'b0);
        end
        bus.pick_valid = 1'b0;
        make_deck(directed);
        for (int k = 0; k < 16; k++) bus.shuf_cards[k] = {3'(sym_m[k]), 2'($urandom_range(3, 0))};
        bus.shuf_done = 1'b0;
        tick();
        check("arm_ready", bus.pick_ready, 1'b0);
        bus.shuf_done = 1'b1;
        tick();
        check("shuf_ready", bus.pick_ready, 1'b1);
        check_all("shuf_latched");
    endtask

    task automatic resolve(input int a, input int b);
        int n;
        check("cmp_ready", bus.pick_ready, 1'b0);
        tick();
        if (sym_m[a] == sym_m[b]) begin
            st_m[a] = 2; st_m[b] = 2;
            score_m[player_m]++;
            pairs_m--;
            check_all("match");
            check("match_game_over", game_over, pairs_m == 0);
            check("match_ready", bus.pick_ready, pairs_m != 0);
        end else begin
            n = 0;
            while (mismatch && n < 20) begin
                n++;
                tick();
            end
            check("show_len", n, SHOW);
            st_m[a] = 0; st_m[b] = 0;
            player_m = 1 - player_m;
            check_all("after_show");
            check("show_ready", bus.pick_ready, 1'b1);
        end
    endtask

    task automatic pick(input int idx);
        bus.pick_valid = 1'b1;
        bus.pick_idx   = 4'(idx);
        tick();
        bus.pick_valid = 1'b0;
        if (st_m[idx] != 0) begin
            check("pick_err", bus.pick_err, 1'b1);
            check("err_cards", cards_out, cards_exp());
            check("err_ready", bus.pick_ready, 1'b1);
        end else begin
            check("pick_err_clear", bus.pick_err, 1'b0);
            st_m[idx] = 1;
            check("faceup", cards_out, cards_exp());
            if (first_m < 0) first_m = idx;
            else begin
                resolve(first_m, idx);
                first_m = -1;
            end
        end
    endtask

    task automatic play_random(input int turns);
        int q[$];
        for (int t = 0; t < turns && pairs_m > 0; t++) begin
            q.delete();
            if ($urandom_range(5, 0) == 0) begin
                for (int k = 0; k < 16; k++) if (st_m[k] != 0) q.push_back(k);
            end
            if (q.size() == 0 && first_m >= 0 && $urandom_range(1, 0) == 1) begin
                for (int k = 0; k < 16; k++) if (k != first_m && sym_m[k] == sym_m[first_m]) q.push_back(k);
            end
            if (q.size() == 0) begin
                for (int k = 0; k < 16; k++) if (st_m[k] == 0) q.push_back(k);
            end
            pick(q[$urandom_range(q.size() - 1, 0)]);
        end
    endtask

    initial begin
        int b;
        rst = 1'b1; new_game = 1'b0;
        bus.shuf_done = 1'b1; bus.shuf_cards = '0; bus.pick_valid = 1'b0; bus.pick_idx = '0;
        tick(); tick();
        check("rst_cards", cards_out, 80'd0);
        check("rst_ready", bus.pick_ready, 1'b0);
        check("rst_shuf_start", bus.shuf_start, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_shuf_start", bus.shuf_start, 1'b0);

        // Game 1: directed opening, then random play to completion.
        start_game(1'b1);
        pick(3); pick(9);
        pick(3);
        pick(0); pick(0); pick(1);
        play_random(400);
        check("game_over", game_over, 1'b1);
        check("score_sum", score0 + score1, 8);
        check_all("final");
        bus.pick_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pick_idx = 4'($urandom);
            tick();
            check("done_pick_err", bus.pick_err, 1'b0);
            check("done_hold", game_over, 1'b1);
            check_all("done_hold");
        end
        bus.pick_valid = 1'b0;

        // Game 2: optional timeout, new_game during SHOW, then reset mid-game.
        start_game(1'b0);
`ifdef MEMORY_GAME_TURN_TIMEOUT_EN
        begin
            int k2;
            pick(5);
            k2 = 1;
            while (!timeout && k2 < 40) begin
                tick();
                k2++;
            end
            check("timeout_len", k2, TMO);
            st_m[5] = 0; player_m = 1 - player_m; first_m = -1;
            check_all("after_timeout");
        end
`endif
        b = 1;
        while (sym_m[b] == sym_m[0]) b++;
        pick(0);
        bus.pick_valid = 1'b1; bus.pick_idx = 4'(b);
        tick();
        bus.pick_valid = 1'b0;
        tick();
        check("show_entered", mismatch, 1'b1);
        start_game(1'b0);
        play_random(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_cards", cards_out, 80'd0);
        check("midrst_scores", {score0, score1}, 8'd0);
        check("midrst_flags", {cur_player, mismatch, game_over}, 3'd0);
        check("midrst_bus", {bus.pick_ready, bus.pick_err, bus.shuf_start}, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Turn-sequencing controller for the 4x4 memory-match game.
- Launches the card shuffler, latches its 16-entry symbol array, and accepts card picks from the input/selector logic.
- Flips, compares, marks matched pairs, and keeps score for two alternating players.
- Drives the per-card state array consumed by the display renderer.

Parameters:
- SHOW_CYCLES, 50_000_000: cycles a mismatched pair stays face-up before flipping back (≥1).
- TIMEOUT_CYCLES, 750_000_000: cycles allowed per turn; used only with TURN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- new_game  in  1  pulse; (re)starts a game from any state
- shuf_start  out  1  one-cycle pulse to shuffler
- shuf_done  in  1  shuffler done level (stays high until next start)
- shuf_cards  in  16x5  shuffler array; symbol in bits [4:2], bits [1:0] ignored
- pick_valid  in  1  card pick request
- pick_idx  in  4  card index 0..15
- pick_ready  out  1  picks are accepted this cycle
- pick_err  out  1  one-cycle pulse: valid pick rejected
- cards_out  out  16x5  per card {symbol[2:0], st[1:0]}; st 00 hidden, 01 face-up, 10 matched
- cur_player  out  1  player whose turn it is
- score0, score1  out  4 each  pairs won per player (0..8)
- mismatch  out  1  high during SHOW
- game_over  out  1  high in DONE

Behaviour:
- Reset (sync, also mid-operation): state IDLE; all outputs 0; cards_out all 0; internal pair counter = 8.
- States: IDLE, SHUF, FIRST, SECOND, CMP, SHOW, DONE.
- IDLE, DONE, or any other state + new_game:
  - next state SHUF; shuf_start pulses for one cycle on SHUF entry.
  - Scores cleared; cur_player = 0; game_over = 0.
  - new_game has priority over every other event in the same cycle.
- SHUF, done handshake:
  - Arm only after shuf_done has been sampled low while in SHUF; this ignores the stale done level from the previous game.
  - After arming, the first high shuf_done latches shuf_cards[k][4:2] into the symbol regs with all st = 00, then go to FIRST.
- FIRST / SECOND:
  - pick_ready = 1.
  - A pick is accepted when pick_valid and st[pick_idx] == 00; that card's st becomes 01 on the next edge.
  - FIRST records idx A and moves to SECOND; SECOND records idx B and moves to CMP.
  - A pick on a face-up or matched card (including the same card twice) is ignored and pulses pick_err; the state is unchanged.
- CMP (exactly 1 cycle, pick_ready = 0):
  - Equal symbols: st[A] = st[B] = 10; score of cur_player += 1; pairs −= 1; cur_player unchanged. Next state is DONE if pairs reaches 0, else FIRST.
  - Unequal symbols: go to SHOW; load the counter with SHOW_CYCLES−1.
- SHOW:
  - mismatch = 1; counter decrements each cycle.
  - At 0: st[A] = st[B] = 00; cur_player toggles; go to FIRST.
  - Total face-up hold is exactly SHOW_CYCLES cycles.
- DONE: game_over = 1; outputs hold until new_game or rst.
- Latency: pick accepted at edge N gives a face-up st visible at N+1. Second pick at edge N gives the match result (st = 10 and score) visible at N+2.
- Scores are 4-bit and saturate at 8 by construction; no wrap.
- pick_err is never asserted in IDLE, SHUF, CMP, SHOW, or DONE; picks in those states are silently dropped.

Optional Feature:
- Macro: MEMORY_GAME_TURN_TIMEOUT_EN.
- When defined:
  - A turn counter loads TIMEOUT_CYCLES−1 on every FIRST entry and counts down through FIRST and SECOND.
  - On expiry, a face-up card A (if any) returns to 00, cur_player toggles, and the state goes to FIRST.
  - An extra output timeout (1 bit) pulses for one cycle on expiry.
  - An accepted pick in the expiry cycle wins over the timeout.
- When undefined: no turn counter, no timeout port; turns wait indefinitely.

Test Plan:
- rst then new_game with shuf_done held high from a prior game: controller stays in SHUF until shuf_done goes low→high. Then cards_out symbols equal shuf_cards[k][4:2], all st = 00, pick_ready = 1.
- Pick 3 then its matching card 9: st[3] and st[9] = 01 for one cycle, then 10; score0 = 1; cur_player stays 0.
- Pick 0 and 1 with different symbols and SHOW_CYCLES = 4: mismatch high for exactly 4 cycles; then st = 00 and cur_player = 1.
- Repick an already-matched card, and repick card A as the second pick: pick_err pulses; state and cards are unchanged.
- Match all 8 pairs: game_over = 1 and score0 + score1 = 8. new_game mid-SHOW returns to SHUF with scores 0. rst mid-game gives all outputs 0.
- With MEMORY_GAME_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 10: pick one card and then idle. Timeout pulses after 10 cycles from FIRST entry, the card returns to hidden, and the player toggles.
